univ_rotate_register: RTL and testbench
=======================================

// Module: univ_rotate_register
// PURPOSE
//   Parameterised universal rotate register: parallel load, rotate left, rotate right or hold, once per clock.
//   Generic datapath primitive for bit-pattern rotation, e.g. one-hot sequencers, barrel-style scramblers and
//   ring counters. All state changes occur on the rising clock edge.
// PARAMETERS
//   DW  4  data/register width in bits; legal range DW >= 2
// PORTS
//   clk       in   1      rising-edge clock, sole clock domain
//   sync_rst  in   1      synchronous, active-low reset: sampled on clk rising edge, 0 clears register
//   ctrl      in   2      operation select (encoding below)
//   data      in   DW     parallel load value, used only when ctrl==2'b00
//   q         out  DW     register contents, driven directly from the flop bank (no comb path from inputs)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low (sync_rst==0 at a rising clk edge -> q <= '0).
//   - Reset has priority over every ctrl value; no asynchronous clear; q undefined only before first edge.
//   - With sync_rst==1, at each rising edge:
//       ctrl=2'b00  LOAD   q <= data
//       ctrl=2'b01  ROTR   q <= {q[0], q[DW-1:1]}      (LSB wraps into MSB)
//       ctrl=2'b10  ROTL   q <= {q[DW-2:0], q[DW-1]}   (MSB wraps into LSB)
//       ctrl=2'b11  HOLD   q <= q
//   - Latency: one cycle from ctrl/data sampled to q updated; q stable between edges.
//   - Rotation is lossless: DW consecutive ROTL (or ROTR) return q to its starting value; popcount(q) invariant
//     under ROTL/ROTR/HOLD.
//   - ROTL followed by ROTR (or vice versa) restores the original value.
//   - data is ignored for all ctrl except 2'b00; changes on data while not loading have no effect.
//   - Reset asserted mid-sequence (any ctrl) clears q on that edge; next non-reset edge acts on q==0
//     (rotating zero yields zero).
//   - ctrl/data must meet setup/hold to clk; no internal synchronisation; no X-propagation special handling.
// STRUCTURE
//   - Shared package: localparam encodings CTRL_LOAD=2'b00, CTRL_ROTR=2'b01, CTRL_ROTL=2'b10, CTRL_HOLD=2'b11.
//   - Optional sub-module rotate_next_val (pure combinational: q, data, ctrl -> next value) feeding a single
//     DW-bit flop bank in the top; top contains only reset muxing and the register.
//   - No other state; no generate beyond width parameterisation.
// TESTING  (DW=4, one op per 10 ns cycle, q checked just before each next edge)
//   1. sync_rst=0 for one edge, any ctrl/data -> q==4'b0000.
//   2. sync_rst=1, ctrl=00, data=4'b1011 -> q==1011; then ctrl=10 x2 -> 0111, then 1110; ctrl=11 x2 -> 1110 held.
//   3. Load 4'b1011, ctrl=01 x2 -> 1101, then 1110; ctrl=11 with data toggling randomly -> q stays 1110.
//   4. Load 4'b1000, ctrl=10 x4 -> 0001,0010,0100,1000 (full wrap); ctrl=01 x4 -> 0100,0010,0001,1000.
//   5. Load 4'b0110, ctrl=10 then sync_rst=0 with ctrl=10 -> 1100 then 0000; release reset, ctrl=01 -> 0000.
//   6. Random regression: alternate load/ROTL/HOLD/ROTR blocks with random data for 50+ cycles; compare
//      every cycle against a reference model using the encoding above -> zero mismatches.

Source files
------------

// File: rtl/univ_rotate_register_pkg.sv
// Shared definitions for the universal rotate register.
package univ_rotate_register_pkg;

    // Operation select encoding carried on the ctrl port.
    typedef enum logic [1:0] {
        CTRL_LOAD = 2'b00,
        CTRL_ROTR = 2'b01,
        CTRL_ROTL = 2'b10,
        CTRL_HOLD = 2'b11
    } ctrl_e;

    // Smallest width for which a rotation is meaningful.
    localparam int unsigned DW_MIN = 2;

endpackage : univ_rotate_register_pkg

// File: rtl/univ_rotate_register_next_val.sv
// Pure combinational next-state function for the rotate register:
// selects load, rotate right, rotate left or hold from the current value.
module rotate_next_val
    import univ_rotate_register_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic [DW-1:0] q,
    input  logic [DW-1:0] data,
    input  ctrl_e         ctrl,
    output logic [DW-1:0] next_val
);

    // Choose the next register value; data only matters for a load.
    always_comb begin
        next_val = q;
        case (ctrl)
            CTRL_LOAD: next_val = data;
            CTRL_ROTR: next_val = {q[0], q[DW-1:1]};
            CTRL_ROTL: next_val = {q[DW-2:0], q[DW-1]};
            CTRL_HOLD: next_val = q;
            default:   next_val = q;
        endcase
    end

endmodule : rotate_next_val

// File: rtl/univ_rotate_register.sv
// Universal rotate register: parallel load, rotate left/right or hold,
// one operation per rising clk edge, synchronous active-low clear.
module univ_rotate_register
    import univ_rotate_register_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic [1:0]    ctrl,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);

    logic [DW-1:0] next_val;

    rotate_next_val #(
        .DW (DW)
    ) u_next_val (
        .q        (q),
        .data     (data),
        .ctrl     (ctrl_e'(ctrl)),
        .next_val (next_val)
    );

    // Single flop bank; reset overrides every ctrl value.
    always_ff @(posedge clk) begin
        if (!sync_rst) begin
            q <= '0;
        end else begin
            q <= next_val;
        end
    end

endmodule : univ_rotate_register

// File: tb/tb_univ_rotate_register.sv
// Self-checking bench for univ_rotate_register (DW=4) using an
// expected-value queue filled at drive time and drained after each edge.
module tb_univ_rotate_register;

    localparam int unsigned DW = 4;

    logic          clk;
    logic          sync_rst;
    logic [1:0]    ctrl;
    logic [DW-1:0] data;
    logic [DW-1:0] q;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [DW-1:0] exp_q[$];
    string         tag_q[$];
    logic [DW-1:0] model;

    univ_rotate_register #(
        .DW (DW)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .ctrl     (ctrl),
        .data     (data),
        .q        (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: q=%b expected %b", tag, got, exp);
        end
    endtask

    // Reference model built bit by bit, independent of slice-based rotation.
    function automatic logic [DW-1:0] model_next(input logic [DW-1:0] cur, input logic r,
                                                 input logic [1:0] c, input logic [DW-1:0] d);
        logic [DW-1:0] n;
        n = cur;
        if (!r) begin
            n = '0;
        end else if (c == 2'b00) begin
            n = d;
        end else if (c == 2'b01) begin
            for (int i = 0; i < int'(DW); i++) n[i] = cur[(i + 1) % DW];
        end else if (c == 2'b10) begin
            for (int i = 0; i < int'(DW); i++) n[(i + 1) % DW] = cur[i];
        end
        return n;
    endfunction

    // Drive one operation, queue its expectation, then compare just before the next edge.
    task automatic step(input string tag, input logic r, input logic [1:0] c,
                        input logic [DW-1:0] d, input logic [DW-1:0] e);
        logic [DW-1:0] want;
        string         t;
        sync_rst = r;
        ctrl     = c;
        data     = d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        model = e;
        @(posedge clk);
        #8;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, q=%b", tag, q);
        end else begin
            want = exp_q.pop_front();
            t    = tag_q.pop_front();
            check(t, q, want);
        end
    endtask

    task automatic mstep(input string tag, input logic r, input logic [1:0] c, input logic [DW-1:0] d);
        step(tag, r, c, d, model_next(model, r, c, d));
    endtask

    initial begin
        sync_rst = 1'b1;
        ctrl     = 2'b11;
        data     = '0;
        model    = '0;

        // Reset
        step("reset", 1'b0, 2'b00, 4'b1111, 4'b0000);

        // Load then rotate left and hold
        step("t2_load",  1'b1, 2'b00, 4'b1011, 4'b1011);
        step("t2_rotl1", 1'b1, 2'b10, 4'b0000, 4'b0111);
        step("t2_rotl2", 1'b1, 2'b10, 4'b0101, 4'b1110);
        step("t2_hold1", 1'b1, 2'b11, 4'b0011, 4'b1110);
        step("t2_hold2", 1'b1, 2'b11, 4'b1001, 4'b1110);

        // Load then rotate right, hold with toggling data
        step("t3_load",  1'b1, 2'b00, 4'b1011, 4'b1011);
        step("t3_rotr1", 1'b1, 2'b01, 4'b0000, 4'b1101);
        step("t3_rotr2", 1'b1, 2'b01, 4'b1111, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            step("t3_hold_data", 1'b1, 2'b11, 4'($urandom_range(0, 15)), 4'b1110);
        end

        // Full wrap in both directions
        step("t4_load",  1'b1, 2'b00, 4'b1000, 4'b1000);
        step("t4_rotl1", 1'b1, 2'b10, 4'b0000, 4'b0001);
        step("t4_rotl2", 1'b1, 2'b10, 4'b0000, 4'b0010);
        step("t4_rotl3", 1'b1, 2'b10, 4'b0000, 4'b0100);
        step("t4_rotl4", 1'b1, 2'b10, 4'b0000, 4'b1000);
        step("t4_rotr1", 1'b1, 2'b01, 4'b0000, 4'b0100);
        step("t4_rotr2", 1'b1, 2'b01, 4'b0000, 4'b0010);
        step("t4_rotr3", 1'b1, 2'b01, 4'b0000, 4'b0001);
        step("t4_rotr4", 1'b1, 2'b01, 4'b0000, 4'b1000);

        // Reset mid-sequence, then rotate zero
        step("t5_load",     1'b1, 2'b00, 4'b0110, 4'b0110);
        step("t5_rotl",     1'b1, 2'b10, 4'b0000, 4'b1100);
        step("t5_rst_rotl", 1'b0, 2'b10, 4'b1111, 4'b0000);
        step("t5_rotr0",    1'b1, 2'b01, 4'b1111, 4'b0000);

        // ROTL then ROTR restores
        step("inv_load", 1'b1, 2'b00, 4'b1001, 4'b1001);
        step("inv_rotl", 1'b1, 2'b10, 4'b0000, 4'b0011);
        step("inv_rotr", 1'b1, 2'b01, 4'b0000, 4'b1001);

        // Random regression: load / ROTL / HOLD / ROTR blocks
        for (int blk = 0; blk < 20; blk++) begin
            logic [1:0] op;
            int unsigned len;
            case (blk % 4)
                0:       op = 2'b00;
                1:       op = 2'b10;
                2:       op = 2'b11;
                default: op = 2'b01;
            endcase
            len = $urandom_range(1, 5);
            for (int k = 0; k < int'(len); k++) begin
                mstep("rand", 1'b1, op, 4'($urandom_range(0, 15)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_univ_rotate_register
